// File: rtl/rgb_led_driver.sv
// -----------------------------------------------------------------------------
// rgb_led_driver
//
// Purpose:
//   Debounces three comparator colour flags into an accepted colour, then
//   drives three LEDs with an 8-bit PWM. Every accepted colour change is
//   announced with a one-cycle pulse and, while enabled, highlighted by a
//   flash of FLASH_PERIODS full PWM periods at 100% drive.
//
// Parameters:
//   STABLE_CYCLES - cycles an input pattern must hold before it is accepted
//                   (must be >= 2)
//   FLASH_PERIODS - full PWM periods of 100% drive after an accepted change
//                   (must be >= 1)
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   en         in   drive enable; low forces IDLE and dark LEDs
//   r_in/g_in/b_in in  raw colour flags from the comparator stage
//   duty       in   PWM duty, on-time = duty/256 of a period
//   led_r/g/b  out  registered LED drives
//   changed    out  one-cycle pulse per accepted colour update
//   onehot_err out  high while the accepted colour is not exactly one-hot
// -----------------------------------------------------------------------------
module rgb_led_driver #(
    parameter int STABLE_CYCLES = 4,
    parameter int FLASH_PERIODS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       r_in,
    input  logic       g_in,
    input  logic       b_in,
    input  logic [7:0] duty,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic       changed,
    output logic       onehot_err
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int FW = (FLASH_PERIODS > 1) ? $clog2(FLASH_PERIODS) : 1;

    localparam logic [SW-1:0] STAB_MAX   = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0] STAB_LAST  = SW'(STABLE_CYCLES - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_PERIODS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLASH
    } state_t;

    // Colour vectors are ordered {r, g, b}: bit 2 = red, bit 0 = blue.
    logic [2:0]    rgb_in;

    logic [2:0]    samp_q,       samp_d;
    logic [SW-1:0] stab_q,       stab_d;
    logic [2:0]    color_q,      color_d;
    logic          changed_q,    changed_d;
    logic          onehot_err_q, onehot_err_d;

    state_t        state_q,      state_d;
    logic [7:0]    pwm_q,        pwm_d;
    logic [7:0]    duty_q,       duty_d;
    logic [FW-1:0] flash_q,      flash_d;
    logic [2:0]    led_q,        led_d;

    logic          accept;
    logic          pwm_wrap;
    logic          drive_en;
    logic          pwm_on;

    assign rgb_in = {r_in, g_in, b_in};

    // -------------------------------------------------------------------------
    // Input filter and colour register (independent of en).
    // samp_q holds the previous sample; the counter measures how many edges
    // in a row the incoming pattern has matched it. Comparing the live input
    // against samp_q lets a pattern first sampled at edge k be accepted at
    // edge k+STABLE_CYCLES.
    // -------------------------------------------------------------------------
    always_comb begin
        samp_d = rgb_in;
        stab_d = stab_q;
        if (rgb_in != samp_q) begin
            stab_d = '0;
        end else if (stab_q != STAB_MAX) begin
            stab_d = stab_q + 1'b1;
        end

        // The counter saturates past STAB_LAST, so a held pattern can only
        // be accepted once; the colour compare suppresses redundant updates.
        accept = (stab_q == STAB_LAST) && (rgb_in == samp_q) && (samp_q != color_q);

        color_d   = accept ? samp_q : color_q;
        changed_d = accept;

        onehot_err_d = !((color_q == 3'b001) || (color_q == 3'b010) || (color_q == 3'b100));
    end

    // -------------------------------------------------------------------------
    // Mode FSM, PWM counter, duty capture and flash period counter.
    // Entering or re-arming FLASH restarts pwm_q at 0 so the flash always
    // lasts exactly FLASH_PERIODS full periods.
    // -------------------------------------------------------------------------
    assign pwm_wrap = (pwm_q == 8'hFF);

    always_comb begin
        state_d = state_q;
        pwm_d   = pwm_q;
        duty_d  = duty_q;
        flash_d = flash_q;

        if (!en) begin
            state_d = ST_IDLE;
            pwm_d   = '0;
            flash_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RUN;
                    pwm_d   = '0;
                    duty_d  = duty;
                end
                ST_RUN: begin
                    pwm_d = pwm_q + 8'd1;
                    if (pwm_wrap) begin
                        duty_d = duty;
                    end
                    if (accept) begin
                        state_d = ST_FLASH;
                        pwm_d   = '0;
                        flash_d = '0;
                    end
                end
                ST_FLASH: begin
                    pwm_d = pwm_q + 8'd1;
                    if (pwm_wrap) begin
                        duty_d = duty;
                    end
                    if (accept) begin
                        pwm_d   = '0;
                        flash_d = '0;
                    end else if (pwm_wrap) begin
                        if (flash_q == FLASH_LAST) begin
                            state_d = ST_RUN;
                            flash_d = '0;
                        end else begin
                            flash_d = flash_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    pwm_d   = '0;
                    flash_d = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // LED drive. en is looked at directly so the LEDs go dark on the first
    // edge after en falls instead of one cycle later with the state.
    // -------------------------------------------------------------------------
    assign drive_en = en && (state_q != ST_IDLE);
    assign pwm_on   = (state_q == ST_FLASH) || (pwm_q < duty_q);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_led
            assign led_d[gi] = drive_en & color_q[gi] & pwm_on;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q       <= '0;
            stab_q       <= '0;
            color_q      <= '0;
            changed_q    <= 1'b0;
            onehot_err_q <= 1'b1;
            state_q      <= ST_IDLE;
            pwm_q        <= '0;
            duty_q       <= '0;
            flash_q      <= '0;
            led_q        <= '0;
        end else begin
            samp_q       <= samp_d;
            stab_q       <= stab_d;
            color_q      <= color_d;
            changed_q    <= changed_d;
            onehot_err_q <= onehot_err_d;
            state_q      <= state_d;
            pwm_q        <= pwm_d;
            duty_q       <= duty_d;
            flash_q      <= flash_d;
            led_q        <= led_d;
        end
    end

    assign led_r      = led_q[2];
    assign led_g      = led_q[1];
    assign led_b      = led_q[0];
    assign changed    = changed_q;
    assign onehot_err = onehot_err_q;

endmodule
